// File: rtl/raw_line_buffer_3row_if.sv
// Stream bundle for raw_line_buffer_3row: RAW 2PPC input and the three aligned row taps.
// The producer/bench drives through the master modport; the line buffer uses the slave modport.
interface raw_line_buffer_3row_if #(
  parameter int unsigned PW = 20
) ();
  logic          i_vsync;
  logic          i_valid;
  logic [PW-1:0] i_pix;
  logic          o_vsync;
  logic          o_valid;
  logic [PW-1:0] o_p_11;
  logic [PW-1:0] o_p_00;
  logic [PW-1:0] o_p_01;

  modport master (
    output i_vsync, i_valid, i_pix,
    input  o_vsync, o_valid, o_p_11, o_p_00, o_p_01
  );

  modport slave (
    input  i_vsync, i_valid, i_pix,
    output o_vsync, o_valid, o_p_11, o_p_00, o_p_01
  );
endinterface

// File: rtl/raw_line_buffer_3row.sv
// Two-line RAM buffer giving the debayer a 3-row (y-1, y, y+1) 2PPC window with 1 clk latency.
// Optional macro RAW_LB_EDGE_REPLICATE_EN: replicate nearest available row instead of zero masking.
module raw_line_buffer_3row #(
  parameter int unsigned P_DEPTH      = 10,
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input logic                     i_pclk,
  input logic                     i_arstn,
  raw_line_buffer_3row_if.slave   io_bus
);
  localparam int unsigned PW    = P_DEPTH * 2;
  localparam int unsigned WORDS = FRAME_WIDTH / 2;
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(WORDS - 1);
  // A frame shorter than two lines can never fill both stored rows.
  localparam logic [1:0] FILL_MAX = (FRAME_HEIGHT >= 2) ? 2'd2 : 2'(FRAME_HEIGHT);

  logic [PW-1:0] r_mem_a [WORDS];
  logic [PW-1:0] r_mem_b [WORDS];
  logic [PW-1:0] r_rd_a, r_rd_b;

  logic          r_vsync, r_valid;
  logic [PW-1:0] r_pix;
  logic [CW-1:0] r_wr_col;
  logic          r_bank_sel, r_sel_s;
  logic [1:0]    r_fill, r_fill_s;

  logic          w_fs, w_we, w_line_end;
  logic [PW-1:0] w_rd_cur, w_rd_old, w_p_00, w_p_11;

  assign w_fs       = !io_bus.i_vsync && r_vsync;
  assign w_we       = io_bus.i_valid && !w_fs;
  assign w_line_end = w_we && (r_wr_col == LAST_COL);

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_vsync    <= 1'b0;
      r_valid    <= 1'b0;
      r_pix      <= '0;
      r_wr_col   <= '0;
      r_bank_sel <= 1'b0;
      r_fill     <= 2'd0;
      r_sel_s    <= 1'b0;
      r_fill_s   <= 2'd0;
    end else begin
      r_vsync  <= io_bus.i_vsync;
      r_valid  <= io_bus.i_valid;
      r_pix    <= io_bus.i_pix;
      // Bank/fill captured alongside the RAM read so the taps are masked consistently.
      r_sel_s  <= r_bank_sel;
      r_fill_s <= r_fill;
      if (w_fs) begin
        r_wr_col   <= '0;
        r_bank_sel <= 1'b0;
        r_fill     <= 2'd0;
      end else if (w_we) begin
        if (w_line_end) begin
          r_wr_col   <= '0;
          r_bank_sel <= ~r_bank_sel;
          if (r_fill < FILL_MAX) r_fill <= r_fill + 2'd1;
        end else begin
          r_wr_col <= r_wr_col + CW'(1);
        end
      end
    end
  end

  // Non-blocking write and read of the same address returns the old line (read-before-write).
  always_ff @(posedge i_pclk) begin
    if (io_bus.i_valid) begin
      r_rd_a <= r_mem_a[r_wr_col];
      r_rd_b <= r_mem_b[r_wr_col];
    end
    if (w_we && !r_bank_sel) r_mem_a[r_wr_col] <= io_bus.i_pix;
    if (w_we && r_bank_sel)  r_mem_b[r_wr_col] <= io_bus.i_pix;
  end

  assign w_rd_cur = r_sel_s ? r_rd_a : r_rd_b;
  assign w_rd_old = r_sel_s ? r_rd_b : r_rd_a;

  always_comb begin
    w_p_00 = w_rd_cur;
    w_p_11 = w_rd_old;
`ifdef RAW_LB_EDGE_REPLICATE_EN
    if (r_fill_s == 2'd0) begin
      w_p_00 = r_pix;
      w_p_11 = r_pix;
    end else if (r_fill_s == 2'd1) begin
      w_p_11 = w_rd_cur;
    end
`else
    if (r_fill_s == 2'd0) begin
      w_p_00 = '0;
      w_p_11 = '0;
    end else if (r_fill_s == 2'd1) begin
      w_p_11 = '0;
    end
`endif
  end

  assign io_bus.o_vsync = r_vsync;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_p_01  = r_pix;
  assign io_bus.o_p_00  = w_p_00;
  assign io_bus.o_p_11  = w_p_11;
endmodule

// File: tb/tb_raw_line_buffer_3row.sv
// Randomized + directed bench for raw_line_buffer_3row against a line-level reference model.
// Model keeps whole stored lines (y, y-1) and a fill count; no banks or RAM ports.
module tb_raw_line_buffer_3row;
  localparam int unsigned WORDS = 4;

  logic clk = 1'b0;
  logic arstn = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  raw_line_buffer_3row_if #(.PW(20)) bus ();

  raw_line_buffer_3row #(
    .P_DEPTH      (10),
    .FRAME_WIDTH  (8),
    .FRAME_HEIGHT (480)
  ) u_dut (
    .i_pclk  (clk),
    .i_arstn (arstn),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference state: completed lines y and y-1, the line being received, column and fill.
  logic [19:0] m_y   [WORDS];
  logic [19:0] m_ym1 [WORDS];
  logic [19:0] m_cur [WORDS];
  int          m_col;
  int          m_fill;
  logic        m_vs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] word(input int l, input int c);
    return 20'((l << 8) | c);
  endfunction

  task automatic model_reset();
    m_col  = 0;
    m_fill = 0;
    m_vs   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check_eq({tag, "_vsync"}, 32'(bus.o_vsync), 32'd0);
    check_eq({tag, "_p01"}, 32'(bus.o_p_01), 32'd0);
    check_eq({tag, "_p00"}, 32'(bus.o_p_00), 32'd0);
    check_eq({tag, "_p11"}, 32'(bus.o_p_11), 32'd0);
  endtask

  // Drive one clock of input, predict the registered result, check it 1 ns after the edge.
  task automatic cycle(input logic vs, input logic v, input logic [19:0] pix);
    logic        fs;
    logic        chk;
    logic [19:0] e00;
    logic [19:0] e11;
    bus.i_vsync = vs;
    bus.i_valid = v;
    bus.i_pix   = pix;
    fs  = !vs && m_vs;
    chk = v && !fs;
`ifdef RAW_LB_EDGE_REPLICATE_EN
    if (m_fill == 0) begin
      e00 = pix;
      e11 = pix;
    end else if (m_fill == 1) begin
      e00 = m_y[m_col];
      e11 = m_y[m_col];
    end else begin
      e00 = m_y[m_col];
      e11 = m_ym1[m_col];
    end
`else
    e00 = (m_fill >= 1) ? m_y[m_col] : 20'd0;
    e11 = (m_fill >= 2) ? m_ym1[m_col] : 20'd0;
`endif
    if (fs) begin
      m_col  = 0;
      m_fill = 0;
    end else if (v) begin
      m_cur[m_col] = pix;
      m_col++;
      if (m_col == WORDS) begin
        m_ym1  = m_y;
        m_y    = m_cur;
        m_col  = 0;
        m_fill = (m_fill < 2) ? m_fill + 1 : 2;
      end
    end
    m_vs = vs;
    @(posedge clk);
    #1;
    check_eq("valid", 32'(bus.o_valid), 32'(v));
    check_eq("vsync", 32'(bus.o_vsync), 32'(vs));
    check_eq("p01", 32'(bus.o_p_01), 32'(pix));
    if (chk) begin
      check_eq("p00", 32'(bus.o_p_00), 32'(e00));
      check_eq("p11", 32'(bus.o_p_11), 32'(e11));
    end
  endtask

  task automatic full_line(input int l);
    for (int c = 0; c < WORDS; c++) cycle(1'b0, 1'b1, word(l, c));
  endtask

  task automatic frame_start();
    cycle(1'b1, 1'b0, 20'd0);
    cycle(1'b0, 1'b0, 20'd0);
  endtask

  initial begin
    logic [6:0] gap_pat;
    int         c;
    bus.i_vsync = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_pix   = 20'hFFFFF;
    model_reset();

    // Reset held with busy inputs: everything must read zero.
    #3 arstn = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 check_zero("rst_hold");
    #2 arstn = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 20'hFFFFF);

    // Frame with lines 0..2, a gappy line 3, line 4, then a short line 5.
    frame_start();
    for (int l = 0; l < 3; l++) full_line(l);
    gap_pat = 7'b1011001;
    c = 0;
    for (int i = 0; i < 7; i++) begin
      if (gap_pat[i]) begin
        cycle(1'b0, 1'b1, word(3, c));
        c++;
      end else begin
        cycle(1'b0, 1'b0, 20'h0BEEF);
      end
    end
    full_line(4);
    cycle(1'b0, 1'b1, word(5, 0));
    cycle(1'b0, 1'b1, word(5, 1));
    cycle(1'b1, 1'b0, 20'd0);
    cycle(1'b0, 1'b1, word(9, 9));

    // New frame after the short line.
    frame_start();
    for (int l = 0; l < 4; l++) full_line(l);

    // Asynchronous reset in mid-line, then restart without a frame start.
    cycle(1'b0, 1'b1, word(4, 0));
    cycle(1'b0, 1'b1, word(4, 1));
    #2 arstn = 1'b0;
    #1 check_zero("rst_midline");
    @(posedge clk);
    #3 arstn = 1'b1;
    model_reset();
    for (int l = 0; l < 3; l++) full_line(l);

    // Random traffic: gaps, random pixels, sporadic frame starts (short and over-long lines).
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            20'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
